// File: rtl/config_loader.sv
// config_loader
//   Streams configuration words from the bitstream port into a shadow
//   register. When the shadow is full, it commits the shadow to one target
//   block at a time with a single-cycle cen pulse. The targets sit in a row
//   and share one config bus.
//
//   cclk        in   config clock, all state on posedge
//   rst         in   synchronous active-high reset
//   start       in   begin a load at block 0 (honoured in IDLE/DONE only)
//   s_valid     in   stream word valid
//   s_ready     out  loader accepts a word this cycle (FILL)
//   s_data      in   stream word
//   config_out  out  shared config bus, driven only during COMMIT
//   cen_out     out  one-hot target enable, pulsed during COMMIT
//   blk_idx     out  block currently being filled/committed
//   busy        out  FILL or COMMIT
//   done        out  all blocks committed
//
//   state  | meaning
//   IDLE   | waiting for start, bus quiet
//   FILL   | accepting words into the shadow for blk_idx
//   COMMIT | one cycle: shadow on bus, cen pulse to blk_idx
//   DONE   | every block loaded, waiting for start or rst
module config_loader #(
    parameter int NUM_BLOCKS = 4,
    parameter int CFG_WIDTH  = 3,
    parameter int WORD_W     = 8,
    localparam int BI_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                  cclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_W-1:0]     s_data,
    output logic [CFG_WIDTH-1:0]  config_out,
    output logic [NUM_BLOCKS-1:0] cen_out,
    output logic [BI_W-1:0]       blk_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int WPB  = (CFG_WIDTH + WORD_W - 1) / WORD_W;
    localparam int WC_W = (WPB > 1) ? $clog2(WPB) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [BI_W-1:0]      blk_idx_q, blk_idx_d;
    logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
    logic [CFG_WIDTH-1:0] shadow_q, shadow_d;

    always_comb begin
        state_d    = state_q;
        blk_idx_d  = blk_idx_q;
        word_cnt_d = word_cnt_q;
        shadow_d   = shadow_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = FILL;
                    blk_idx_d  = '0;
                    word_cnt_d = '0;
                    shadow_d   = '0;
                end
            end
            FILL: begin
                if (s_valid) begin
                    // Each shadow bit belongs to exactly one word slot; bits of
                    // the final word beyond CFG_WIDTH have no home and drop out.
                    for (int b = 0; b < CFG_WIDTH; b++) begin
                        if (int'(word_cnt_q) == (b / WORD_W)) begin
                            shadow_d[b] = s_data[b % WORD_W];
                        end
                    end
                    if (word_cnt_q == WC_W'(WPB - 1)) begin
                        state_d    = COMMIT;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                if (blk_idx_q == BI_W'(NUM_BLOCKS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d    = FILL;
                    blk_idx_d  = blk_idx_q + 1'b1;
                    word_cnt_d = '0;
                    shadow_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q    <= IDLE;
            blk_idx_q  <= '0;
            word_cnt_q <= '0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            blk_idx_q  <= blk_idx_d;
            word_cnt_q <= word_cnt_d;
            shadow_q   <= shadow_d;
        end
    end

    // Moore outputs decoded from registered state only.
    assign s_ready    = (state_q == FILL);
    assign busy       = (state_q == FILL) || (state_q == COMMIT);
    assign done       = (state_q == DONE);
    assign blk_idx    = blk_idx_q;
    assign config_out = (state_q == COMMIT) ? shadow_q : '0;
    assign cen_out    = (state_q == COMMIT) ? (NUM_BLOCKS'(1) << blk_idx_q) : '0;

endmodule
